// File: rtl/eth_tx_pkt_buf_pkg.sv
// rtl/eth_tx_pkt_buf_pkg.sv - shared constants, FSM encoding and length helper for the tx packet buffer
package eth_tx_pkt_buf_pkg;

    localparam int MIN_PAYLOAD      = 46;
    localparam int MAX_PAYLOAD_DFLT = 1500;
    localparam int LEN_W            = 11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_READ    = 3'd3,
        ST_GAP     = 3'd4
    } tx_state_t;

    // Length announced to eth_send; optionally raised to the minimum payload.
    function automatic logic [15:0] frame_len(input logic [LEN_W-1:0] len, input logic pad);
        logic [15:0] l;
        l = {{(16-LEN_W){1'b0}}, len};
        if (pad && (l < 16'(MIN_PAYLOAD)))
            l = 16'(MIN_PAYLOAD);
        return l;
    endfunction

endpackage

// File: rtl/eth_tx_pkt_buf_desc_fifo.sv
// rtl/eth_tx_pkt_buf_desc_fifo.sv - show-ahead sync FIFO of {start, len} packet descriptors
module eth_tx_desc_fifo #(
    parameter int WIDTH   = 23,
    parameter int DEPTH_W = 2
) (
    input  logic               gmii_tx_clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   head,
    output logic [DEPTH_W:0]   count,
    output logic               full
);

    logic [WIDTH-1:0] mem [2**DEPTH_W];
    logic [DEPTH_W:0] wp;
    logic [DEPTH_W:0] rp;

    assign count = wp - rp;
    assign full  = count[DEPTH_W];
    assign head  = mem[rp[DEPTH_W-1:0]];

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full)
                wp <= wp + 1'b1;
            if (pop && (count != '0))
                rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (push && !full)
            mem[wp[DEPTH_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/eth_tx_pkt_buf.sv
// rtl/eth_tx_pkt_buf.sv - whole-packet tx buffer feeding eth_send; ETH_TXBUF_PAD_EN pads length to 46
module eth_tx_pkt_buf
    import eth_tx_pkt_buf_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int DESC_W      = 2,
    parameter int MAX_PAYLOAD = MAX_PAYLOAD_DFLT,
    parameter int GAP_CYCLES  = 24
) (
    input  logic              gmii_tx_clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    output logic              wr_drop,
    output logic              tx_en,
    output logic [15:0]       fifo_data_length,
    input  logic              fifo_rdreq,
    output logic [7:0]        fifo_data,
    output logic [DESC_W:0]   pkt_count,
    output logic              busy
);

`ifdef ETH_TXBUF_PAD_EN
    localparam logic PAD_EN = 1'b1;
`else
    localparam logic PAD_EN = 1'b0;
`endif

    localparam int PW = ADDR_W + 1;
    localparam int DW = PW + LEN_W;

    logic [7:0]       ram [2**ADDR_W];
    logic [7:0]       ram_q;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    wr_tmp;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_addr;
    logic [PW-1:0]    rd_addr_nxt;
    logic [PW-1:0]    used;
    logic [LEN_W-1:0] wr_len;
    logic             dropping;
    logic             pkt_open;
    logic             oversize;
    logic             store;
    logic             commit;
    logic             drop_start;

    tx_state_t        state;
    logic [PW-1:0]    cur_start;
    logic [LEN_W-1:0] cur_len;
    logic [15:0]      rd_idx;
    logic [15:0]      gap_cnt;

    logic [DW-1:0]    desc_head;
    logic [PW-1:0]    hd_start;
    logic [LEN_W-1:0] hd_len;
    logic             desc_full;
    logic             pop;

    // Full/empty distinguished by the extra pointer bit: used == 2**ADDR_W means full.
    assign used       = wr_tmp - rd_ptr;
    assign pkt_open   = (wr_tmp != wr_ptr);
    assign wr_ready   = !used[ADDR_W] && (pkt_open || !desc_full);
    assign oversize   = 32'(wr_len) >= 32'(MAX_PAYLOAD);
    assign store      = wr_valid && wr_ready && !dropping && !oversize;
    assign commit     = store && wr_last;
    assign drop_start = wr_valid && !dropping && !store;

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            wr_tmp   <= '0;
            wr_len   <= '0;
            dropping <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            wr_drop <= 1'b0;
            if (store) begin
                wr_tmp <= wr_tmp + 1'b1;
                wr_len <= wr_len + 1'b1;
                if (wr_last) begin
                    wr_ptr <= wr_tmp + 1'b1;
                    wr_len <= '0;
                end
            end else if (drop_start) begin
                wr_tmp   <= wr_ptr;
                wr_len   <= '0;
                dropping <= !wr_last;
                wr_drop  <= wr_last;
            end else if (dropping && wr_valid && wr_last) begin
                dropping <= 1'b0;
                wr_drop  <= 1'b1;
            end
        end
    end

    eth_tx_desc_fifo #(
        .WIDTH   (DW),
        .DEPTH_W (DESC_W)
    ) u_desc_fifo (
        .gmii_tx_clk (gmii_tx_clk),
        .rst_n       (rst_n),
        .push        (commit),
        .push_data   ({wr_ptr, wr_len + 1'b1}),
        .pop         (pop),
        .head        (desc_head),
        .count       (pkt_count),
        .full        (desc_full)
    );

    assign hd_start = desc_head[DW-1:LEN_W];
    assign hd_len   = desc_head[LEN_W-1:0];
    assign pop      = (state == ST_START);

    // Read address runs one step ahead so ram_q always holds the byte at rd_addr.
    always_comb begin
        rd_addr_nxt = rd_addr;
        if (state == ST_START)
            rd_addr_nxt = hd_start;
        else if (((state == ST_WAIT_RD) || (state == ST_READ)) && fifo_rdreq)
            rd_addr_nxt = rd_addr + 1'b1;
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (store)
            ram[wr_tmp[ADDR_W-1:0]] <= wr_data;
        ram_q <= ram[rd_addr_nxt[ADDR_W-1:0]];
    end

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            tx_en            <= 1'b0;
            fifo_data_length <= '0;
            rd_addr          <= '0;
            rd_ptr           <= '0;
            cur_start        <= '0;
            cur_len          <= '0;
            rd_idx           <= '0;
            gap_cnt          <= '0;
        end else begin
            tx_en   <= 1'b0;
            rd_addr <= rd_addr_nxt;
            case (state)
                ST_IDLE: begin
                    if (pkt_count != '0)
                        state <= ST_START;
                end
                ST_START: begin
                    tx_en            <= 1'b1;
                    cur_start        <= hd_start;
                    cur_len          <= hd_len;
                    rd_ptr           <= hd_start;
                    rd_idx           <= '0;
                    fifo_data_length <= frame_len(hd_len, PAD_EN);
                    state            <= ST_WAIT_RD;
                end
                ST_WAIT_RD: begin
                    if (fifo_rdreq) begin
                        rd_idx <= rd_idx + 1'b1;
                        state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (fifo_rdreq) begin
                        rd_idx <= rd_idx + 1'b1;
                    end else begin
                        rd_ptr  <= cur_start + PW'(cur_len);
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 16'(GAP_CYCLES - 1))
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign fifo_data = (((state == ST_WAIT_RD) || (state == ST_READ)) &&
                        (rd_idx < {{(16-LEN_W){1'b0}}, cur_len})) ? ram_q : 8'h00;

endmodule

// File: tb/tb_eth_tx_pkt_buf.sv
// tb/tb_eth_tx_pkt_buf.sv - directed scoreboard bench for eth_tx_pkt_buf (default and 64-byte RAM builds)
module tb_eth_tx_pkt_buf;

    localparam int GAP = 24;
`ifdef ETH_TXBUF_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic       gmii_tx_clk = 1'b0;
    logic       rst_n       = 1'b0;
    logic       sel         = 1'b0;
    logic       wr_valid    = 1'b0;
    logic       wr_last     = 1'b0;
    logic [7:0] wr_data     = 8'h00;
    logic       fifo_rdreq  = 1'b0;

    logic        a_wr_ready, a_wr_drop, a_tx_en, a_busy;
    logic [15:0] a_len;
    logic [7:0]  a_data;
    logic [2:0]  a_cnt;
    logic        b_wr_ready, b_wr_drop, b_tx_en, b_busy;
    logic [15:0] b_len;
    logic [7:0]  b_data;
    logic [2:0]  b_cnt;

    logic        m_wr_ready, m_wr_drop, m_tx_en, m_busy;
    logic [15:0] m_len;
    logic [7:0]  m_data;
    logic [2:0]  m_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_commit = 0;
    int tx_q[$];
    logic [7:0] sb_data[$];
    int sb_len[$];

    always #4 gmii_tx_clk = ~gmii_tx_clk;
    always @(posedge gmii_tx_clk) cyc <= cyc + 1;
    always @(negedge gmii_tx_clk) if (m_tx_en) tx_q.push_back(cyc);

    eth_tx_pkt_buf dut_a (
        .gmii_tx_clk      (gmii_tx_clk),
        .rst_n            (rst_n),
        .wr_valid         (wr_valid && !sel),
        .wr_data          (wr_data),
        .wr_last          (wr_last),
        .wr_ready         (a_wr_ready),
        .wr_drop          (a_wr_drop),
        .tx_en            (a_tx_en),
        .fifo_data_length (a_len),
        .fifo_rdreq       (fifo_rdreq && !sel),
        .fifo_data        (a_data),
        .pkt_count        (a_cnt),
        .busy             (a_busy)
    );

    eth_tx_pkt_buf #(.ADDR_W(6)) dut_b (
        .gmii_tx_clk      (gmii_tx_clk),
        .rst_n            (rst_n),
        .wr_valid         (wr_valid && sel),
        .wr_data          (wr_data),
        .wr_last          (wr_last),
        .wr_ready         (b_wr_ready),
        .wr_drop          (b_wr_drop),
        .tx_en            (b_tx_en),
        .fifo_data_length (b_len),
        .fifo_rdreq       (fifo_rdreq && sel),
        .fifo_data        (b_data),
        .pkt_count        (b_cnt),
        .busy             (b_busy)
    );

    assign m_wr_ready = sel ? b_wr_ready : a_wr_ready;
    assign m_wr_drop  = sel ? b_wr_drop  : a_wr_drop;
    assign m_tx_en    = sel ? b_tx_en    : a_tx_en;
    assign m_busy     = sel ? b_busy     : a_busy;
    assign m_len      = sel ? b_len      : a_len;
    assign m_data     = sel ? b_data     : a_data;
    assign m_cnt      = sel ? b_cnt      : a_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_pkt(input int n, input bit keep, input int full_at);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (i == full_at) check("wr_ready_full", 32'(m_wr_ready), 32'd0);
            wr_valid = 1'b1;
            wr_data  = b;
            wr_last  = (i == n - 1);
            if (keep) sb_data.push_back(b);
            @(posedge gmii_tx_clk);
            @(negedge gmii_tx_clk);
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        if (keep) sb_len.push_back(n);
        last_commit = cyc;
    endtask

    task automatic recv_pkt(input int limit, output int tx_cyc);
        int waited, len, flen, nread;
        logic [7:0] exp;
        waited = 0;
        tx_cyc = 0;
        while (tx_q.size() == 0 && waited < 3000) begin
            @(negedge gmii_tx_clk);
            waited++;
        end
        check("tx_en_seen", 32'(tx_q.size() != 0), 32'd1);
        if (tx_q.size() == 0 || sb_len.size() == 0) return;
        tx_cyc = tx_q.pop_front();
        len    = sb_len.pop_front();
        flen   = (PAD && len < 46) ? 46 : len;
        check("frame_len", 32'(m_len), 32'(flen));
        nread  = (len < 46) ? 46 : len;
        if (limit < nread) nread = limit;
        for (int i = 0; i < nread; i++) begin
            fifo_rdreq = 1'b1;
            if (i < len) exp = sb_data.pop_front();
            else         exp = 8'h00;
            check($sformatf("fifo_data[%0d]", i), 32'(m_data), 32'(exp));
            @(posedge gmii_tx_clk);
            @(negedge gmii_tx_clk);
        end
        fifo_rdreq = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (GAP + 4) @(negedge gmii_tx_clk);
        check("busy_idle", 32'(m_busy), 32'd0);
        check("pkt_count_idle", 32'(m_cnt), 32'd0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_tx_en"},    32'(m_tx_en),    32'd0);
        check({pfx, "_wr_ready"}, 32'(m_wr_ready), 32'd1);
        check({pfx, "_wr_drop"},  32'(m_wr_drop),  32'd0);
        check({pfx, "_data"},     32'(m_data),     32'd0);
        check({pfx, "_len"},      32'(m_len),      32'd0);
        check({pfx, "_pkt_cnt"},  32'(m_cnt),      32'd0);
        check({pfx, "_busy"},     32'(m_busy),     32'd0);
    endtask

    initial begin
        int t1, t2;
        repeat (3) @(negedge gmii_tx_clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge gmii_tx_clk);

        // ARP-sized payload: latency, length and pad bytes
        send_pkt(28, 1'b1, -1);
        check("pkt_count_commit", 32'(m_cnt), 32'd1);
        check("wr_drop_none", 32'(m_wr_drop), 32'd0);
        recv_pkt(1000, t1);
        check("tx_latency", 32'(t1 - last_commit), 32'd2);
        wait_idle();

        // two packets back to back
        send_pkt(100, 1'b1, -1);
        send_pkt(60, 1'b1, -1);
        check("pkt_count_b2b", 32'(m_cnt), 32'd1);
        recv_pkt(1000, t1);
        recv_pkt(1000, t2);
        check("tx_spacing", 32'((t2 - t1) >= 100 + GAP), 32'd1);
        wait_idle();

        // small RAM overflow, then a normal packet
        sel = 1'b1;
        @(negedge gmii_tx_clk);
        send_pkt(70, 1'b0, 64);
        check("ovf_drop", 32'(m_wr_drop), 32'd1);
        check("ovf_pkt_count", 32'(m_cnt), 32'd0);
        repeat (10) @(negedge gmii_tx_clk);
        check("ovf_no_tx", 32'(tx_q.size()), 32'd0);
        send_pkt(10, 1'b1, -1);
        recv_pkt(1000, t1);
        wait_idle();
        sel = 1'b0;
        @(negedge gmii_tx_clk);

        // oversize packet dropped, then minimum-size packet
        send_pkt(1501, 1'b0, -1);
        check("big_drop", 32'(m_wr_drop), 32'd1);
        check("big_pkt_count", 32'(m_cnt), 32'd0);
        @(negedge gmii_tx_clk);
        check("big_drop_pulse", 32'(m_wr_drop), 32'd0);
        repeat (10) @(negedge gmii_tx_clk);
        check("big_no_tx", 32'(tx_q.size()), 32'd0);
        send_pkt(46, 1'b1, -1);
        recv_pkt(1000, t1);
        wait_idle();

        // reset in the middle of a frame with another packet queued
        send_pkt(60, 1'b1, -1);
        send_pkt(30, 1'b1, -1);
        check("mid_pkt_count", 32'(m_cnt), 32'd1);
        recv_pkt(20, t1);
        check("mid_busy", 32'(m_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb_data.delete();
        sb_len.delete();
        tx_q.delete();
        @(negedge gmii_tx_clk);
        rst_n = 1'b1;
        repeat (40) @(negedge gmii_tx_clk);
        check("post_rst_no_tx", 32'(tx_q.size()), 32'd0);
        check("post_rst_busy", 32'(m_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
